// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared state type and sizing helper for the matrix row packer
package matmul_pkg;

  typedef enum logic {
    FILL  = 1'b0,
    DRAIN = 1'b1
  } packer_state_t;

  // Row counter width: a one-row matrix still needs a 1-bit counter.
  function automatic int cnt_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/matrix_flatten.sv
// rtl/matrix_flatten.sv - packs a row-major element buffer into one flat word, element 0 at the LSBs
module matrix_flatten
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIM0       = 4,
  parameter int DIM1       = 4
) (
  input  logic [DATA_WIDTH-1:0]           i_elem [DIM0*DIM1],
  output logic [DATA_WIDTH*DIM0*DIM1-1:0] o_flat
);

  for (genvar i = 0; i < DIM0*DIM1; i++) begin : g_elem
    assign o_flat[i*DATA_WIDTH +: DATA_WIDTH] = i_elem[i];
  end

endmodule

// File: rtl/matrix_row_packer.sv
// rtl/matrix_row_packer.sv - collects DIM0 rows into one flattened matrix; MATRIX_ROW_PACKER_LAST_EN adds short-matrix support
module matrix_row_packer
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DIM0       = 4,
  parameter int DIM1       = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATA_WIDTH-1:0]          data_in [DIM1],
  input  logic                           data_in_valid,
  output logic                           data_in_ready,
  output logic [DATA_WIDTH*DIM0*DIM1-1:0] data_out,
  output logic                           data_out_valid,
  input  logic                           data_out_ready
`ifdef MATRIX_ROW_PACKER_LAST_EN
  ,
  input  logic                           data_in_last,
  output logic                           err_short
`endif
);

  localparam int            CW       = cnt_width(DIM0);
  localparam logic [CW-1:0] LAST_ROW = CW'(DIM0 - 1);

  packer_state_t         r_state;
  logic [CW-1:0]         r_row_cnt;
  logic [DATA_WIDTH-1:0] r_buf [DIM0*DIM1];

  logic          w_in_fire;
  logic          w_out_fire;
  logic          w_close;
  logic [CW-1:0] w_slot;

  assign data_out_valid = (r_state == DRAIN);
  assign data_in_ready  = (r_state == FILL) ? 1'b1 : data_out_ready;
  assign w_in_fire      = data_in_valid & data_in_ready;
  assign w_out_fire     = data_out_valid & data_out_ready;
  // A row accepted while draining can only land when the old matrix leaves, so it starts a new one.
  assign w_slot         = (r_state == FILL) ? r_row_cnt : '0;

`ifdef MATRIX_ROW_PACKER_LAST_EN
  logic r_err_short;
  assign err_short = r_err_short;
  assign w_close   = (w_slot == LAST_ROW) | data_in_last;
`else
  assign w_close   = (w_slot == LAST_ROW);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= FILL;
      r_row_cnt <= '0;
      for (int i = 0; i < DIM0*DIM1; i++) r_buf[i] <= '0;
`ifdef MATRIX_ROW_PACKER_LAST_EN
      r_err_short <= 1'b0;
`endif
    end else if (w_in_fire) begin
      for (int r = 0; r < DIM0; r++) begin
        for (int c = 0; c < DIM1; c++) begin
          if (CW'(r) == w_slot) r_buf[r*DIM1+c] <= data_in[c];
`ifdef MATRIX_ROW_PACKER_LAST_EN
          else if (w_close && (CW'(r) > w_slot)) r_buf[r*DIM1+c] <= '0;
`endif
        end
      end
      if (w_close) begin
        r_state   <= DRAIN;
        r_row_cnt <= '0;
      end else begin
        r_state   <= FILL;
        r_row_cnt <= w_slot + CW'(1);
      end
`ifdef MATRIX_ROW_PACKER_LAST_EN
      if (data_in_last && (w_slot != LAST_ROW)) r_err_short <= 1'b1;
`endif
    end else if (w_out_fire) begin
      r_state   <= FILL;
      r_row_cnt <= '0;
    end
  end

  matrix_flatten #(
    .DATA_WIDTH(DATA_WIDTH),
    .DIM0      (DIM0),
    .DIM1      (DIM1)
  ) u_flatten (
    .i_elem(r_buf),
    .o_flat(data_out)
  );

endmodule

// File: tb/tb_matrix_row_packer.sv
// tb/tb_matrix_row_packer.sv - randomized scoreboard bench for a 2x2 and a 1x2 packer, optional MATRIX_ROW_PACKER_LAST_EN
module tb_matrix_row_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [7:0]  din [2];
  logic        din_valid, din_ready;
  logic [31:0] dout;
  logic        dout_valid, dout_ready;

  logic [7:0]  d1_in [2];
  logic        d1_valid, d1_ready;
  logic [15:0] d1_out;
  logic        d1_out_valid, d1_out_ready;

`ifdef MATRIX_ROW_PACKER_LAST_EN
  logic din_last, err_short, d1_last, d1_err;
`endif

  int vectors = 0;
  int errors  = 0;

  logic [31:0] m_q[$];
  logic [31:0] m_acc;
  int          m_rows;
  logic [15:0] m1_q[$];
  int          acc_rows, out_mats, acc1, out1;

  matrix_row_packer #(.DATA_WIDTH(8), .DIM0(2), .DIM1(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .data_in(din), .data_in_valid(din_valid), .data_in_ready(din_ready),
    .data_out(dout), .data_out_valid(dout_valid), .data_out_ready(dout_ready)
`ifdef MATRIX_ROW_PACKER_LAST_EN
    , .data_in_last(din_last), .err_short(err_short)
`endif
  );

  matrix_row_packer #(.DATA_WIDTH(8), .DIM0(1), .DIM1(2)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .data_in(d1_in), .data_in_valid(d1_valid), .data_in_ready(d1_ready),
    .data_out(d1_out), .data_out_valid(d1_out_valid), .data_out_ready(d1_out_ready)
`ifdef MATRIX_ROW_PACKER_LAST_EN
    , .data_in_last(d1_last), .err_short(d1_err)
`endif
  );

  // Reference: rows accumulate into a matrix; a finished matrix waits in a one-deep queue.
  task automatic tick();
    bit in_f, out_f, last;
    if (!rst_n) begin
      m_q.delete();
      m1_q.delete();
      m_rows = 0;
      m_acc  = '0;
    end else begin
      last = 1'b0;
`ifdef MATRIX_ROW_PACKER_LAST_EN
      last = din_last;
`endif
      out_f = (m_q.size() != 0) && dout_ready;
      in_f  = din_valid && ((m_q.size() == 0) || dout_ready);
      if (out_f) begin
        void'(m_q.pop_front());
        out_mats++;
      end
      if (in_f) begin
        if (m_rows == 0) m_acc = '0;
        m_acc = m_acc | (32'({din[1], din[0]}) << (16 * m_rows));
        m_rows++;
        acc_rows++;
        if (m_rows == 2 || last) begin
          m_q.push_back(m_acc);
          m_rows = 0;
        end
      end
      out_f = (m1_q.size() != 0) && d1_out_ready;
      in_f  = d1_valid && ((m1_q.size() == 0) || d1_out_ready);
      if (out_f) begin
        void'(m1_q.pop_front());
        out1++;
      end
      if (in_f) begin
        m1_q.push_back({d1_in[1], d1_in[0]});
        acc1++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    din_valid = 1'b0; dout_ready = 1'b0; d1_valid = 1'b0; d1_out_ready = 1'b0;
    din = '{8'h00, 8'h00}; d1_in = '{8'h00, 8'h00};
`ifdef MATRIX_ROW_PACKER_LAST_EN
    din_last = 1'b0; d1_last = 1'b0;
`endif
    tick(); tick();
    vectors++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %b want 0", dout_valid); end
    vectors++; if (dout !== 32'h0) begin errors++; $display("FAIL rst_data_out: got %h want 0", dout); end
    vectors++; if (d1_out_valid !== 1'b0) begin errors++; $display("FAIL rst_d1_out_valid: got %b want 0", d1_out_valid); end
`ifdef MATRIX_ROW_PACKER_LAST_EN
    vectors++; if (err_short !== 1'b0) begin errors++; $display("FAIL rst_err_short: got %b want 0", err_short); end
`endif
    rst_n = 1'b1;
    #1;
    vectors++; if (din_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b want 1", din_ready); end
    vectors++; if (d1_ready !== 1'b1) begin errors++; $display("FAIL rst_d1_in_ready: got %b want 1", d1_ready); end
  endtask

  task automatic test_basic();
    dout_ready = 1'b1; din_valid = 1'b1;
    din = '{8'h01, 8'h02}; #1; tick();
    vectors++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b want 0", dout_valid); end
    din = '{8'h03, 8'h04}; #1; tick();
    vectors++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", dout_valid); end
    vectors++; if (dout !== 32'h04030201) begin errors++; $display("FAIL basic_data: got %h want 04030201", dout); end
    din_valid = 1'b0; #1; tick();
    vectors++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_one_cycle: got %b want 0", dout_valid); end
  endtask

  task automatic test_stall();
    dout_ready = 1'b0; din_valid = 1'b1;
    din = '{8'($urandom), 8'($urandom)}; #1; tick();
    din = '{8'($urandom), 8'($urandom)}; #1; tick();
    din = '{8'($urandom), 8'($urandom)};
    for (int i = 0; i < 5; i++) begin
      #1;
      vectors++; if (din_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready[%0d]: got %b want 0", i, din_ready); end
      vectors++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b want 1", i, dout_valid); end
      vectors++; if (dout !== m_q[0]) begin errors++; $display("FAIL stall_data[%0d]: got %h want %h", i, dout, m_q[0]); end
      tick();
    end
    dout_ready = 1'b1; din_valid = 1'b0; #1;
    vectors++; if (dout !== m_q[0]) begin errors++; $display("FAIL stall_release: got %h want %h", dout, m_q[0]); end
    tick();
    vectors++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL stall_drained: got %b want 0", dout_valid); end
  endtask

  task automatic test_back_to_back();
    acc_rows = 0; out_mats = 0;
    dout_ready = 1'b1; din_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = '{8'($urandom), 8'($urandom)}; #1;
      vectors++; if (din_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, din_ready); end
      vectors++; if (dout_valid !== (i >= 2 && i % 2 == 0)) begin errors++; $display("FAIL b2b_valid[%0d]: got %b want %b", i, dout_valid, (i >= 2 && i % 2 == 0)); end
      if (m_q.size() != 0) begin
        vectors++; if (dout !== m_q[0]) begin errors++; $display("FAIL b2b_data[%0d]: got %h want %h", i, dout, m_q[0]); end
      end
      tick();
    end
    din_valid = 1'b0; #1;
    vectors++; if (dout !== m_q[0]) begin errors++; $display("FAIL b2b_last_data: got %h want %h", dout, m_q[0]); end
    tick();
    vectors++; if (acc_rows != 20 || out_mats != 10) begin errors++; $display("FAIL b2b_counts: got rows=%0d mats=%0d want rows=20 mats=10", acc_rows, out_mats); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 80; i++) begin
      din = '{8'($urandom), 8'($urandom)};
      din_valid  = (i < 76) ? ($urandom_range(0, 9) < 7) : 1'b0;
      dout_ready = (i < 76) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      vectors++; if (dout_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, dout_valid, (m_q.size() != 0)); end
      vectors++; if (din_ready !== ((m_q.size() == 0) || dout_ready)) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, din_ready, ((m_q.size() == 0) || dout_ready)); end
      if (m_q.size() != 0) begin
        vectors++; if (dout !== m_q[0]) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, dout, m_q[0]); end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    dout_ready = 1'b1; din_valid = 1'b1;
    din = '{8'h55, 8'h66}; #1; tick();
    din_valid = 1'b0; rst_n = 1'b0; #1;
    vectors++; if (dout !== 32'h0) begin errors++; $display("FAIL mid_rst_data: got %h want 0", dout); end
    tick();
    rst_n = 1'b1; din_valid = 1'b1;
    din = '{8'h11, 8'h22}; #1; tick();
    vectors++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_stale_valid: got %b want 0", dout_valid); end
    din = '{8'h33, 8'h44}; #1; tick();
    vectors++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL mid_rst_valid: got %b want 1", dout_valid); end
    vectors++; if (dout !== 32'h44332211) begin errors++; $display("FAIL mid_rst_data_out: got %h want 44332211", dout); end
    din_valid = 1'b0; #1; tick();
  endtask

  task automatic test_dim1();
    acc1 = 0; out1 = 0;
    for (int i = 0; i < 50; i++) begin
      d1_in = '{8'($urandom), 8'($urandom)};
      d1_valid     = (i < 46);
      d1_out_ready = (i < 46) ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      vectors++; if (d1_out_valid !== (m1_q.size() != 0)) begin errors++; $display("FAIL d1_valid[%0d]: got %b want %b", i, d1_out_valid, (m1_q.size() != 0)); end
      vectors++; if (d1_ready !== ((m1_q.size() == 0) || d1_out_ready)) begin errors++; $display("FAIL d1_in_ready[%0d]: got %b want %b", i, d1_ready, ((m1_q.size() == 0) || d1_out_ready)); end
      if (m1_q.size() != 0) begin
        vectors++; if (d1_out !== m1_q[0]) begin errors++; $display("FAIL d1_data[%0d]: got %h want %h", i, d1_out, m1_q[0]); end
      end
      tick();
    end
    vectors++; if (acc1 != out1 || acc1 < 10) begin errors++; $display("FAIL d1_counts: got accepted=%0d emitted=%0d want equal and >=10", acc1, out1); end
  endtask

`ifdef MATRIX_ROW_PACKER_LAST_EN
  task automatic test_last();
    dout_ready = 1'b1; din_valid = 1'b1; din_last = 1'b1;
    din = '{8'hAA, 8'hBB}; #1; tick();
    vectors++; if (dout_valid !== 1'b1) begin errors++; $display("FAIL last_valid: got %b want 1", dout_valid); end
    vectors++; if (dout !== 32'h0000BBAA) begin errors++; $display("FAIL last_data: got %h want 0000bbaa", dout); end
    vectors++; if (err_short !== 1'b1) begin errors++; $display("FAIL last_err_short: got %b want 1", err_short); end
    din_last = 1'b0;
    din = '{8'h12, 8'h34}; #1; tick();
    din_last = 1'b1;
    din = '{8'h56, 8'h78}; #1; tick();
    vectors++; if (dout !== 32'h78563412) begin errors++; $display("FAIL last_full_data: got %h want 78563412", dout); end
    din_valid = 1'b0; din_last = 1'b0; #1; tick();
    vectors++; if (err_short !== 1'b1) begin errors++; $display("FAIL last_sticky: got %b want 1", err_short); end
    rst_n = 1'b0; #1; tick();
    rst_n = 1'b1; #1;
    vectors++; if (err_short !== 1'b0) begin errors++; $display("FAIL last_err_cleared: got %b want 0", err_short); end
  endtask
`endif

  initial begin
    rst_n = 1'b0;
    m_rows = 0; m_acc = '0;
    acc_rows = 0; out_mats = 0; acc1 = 0; out1 = 0;
    test_reset();
    test_basic();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_dim1();
`ifdef MATRIX_ROW_PACKER_LAST_EN
    test_last();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
